and_nbm_qual: RTL and testbench

- Parametrised, registered successor to the fixed 5-input AND-with-inverted-inputs primitive cells.
- Each of CHANNELS lanes computes a WIDTH-input AND term with a per-bit input inversion mask.
- The term is sampled on the clock and qualified: a lane's output asserts only after its term has held true for QUAL consecutive enabled cycles.
- Used as a glitch-free decode / match detector sitting behind combinational library gates.

---
 rtl/and_nbm_qual_if.sv | 26 ++
 rtl/and_nbm_qual.sv | 94 +++++++++
 tb/tb_and_nbm_qual.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/and_nbm_qual_if.sv
// Bus bundle for and_nbm_qual: clock enable, channel inputs and qualified outputs.
// HITS/HCLR exist only when AND_HIT_COUNT_EN is defined.
interface and_nbm_qual_if #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned HIT_W    = 8
);
  logic                      CE;
  logic [CHANNELS*WIDTH-1:0] I;
  logic [CHANNELS-1:0]       O;
  logic [CHANNELS-1:0]       RISE;
`ifdef AND_HIT_COUNT_EN
  logic [CHANNELS*HIT_W-1:0] HITS;
  logic                      HCLR;

  modport master (output CE, I, HCLR, input O, RISE, HITS);
  modport slave  (input CE, I, HCLR, output O, RISE, HITS);
`else
  modport master (output CE, I, input O, RISE);
  modport slave  (input CE, I, output O, RISE);
`endif

  if (HIT_W < 1) begin : g_bad_hit_w
    $error("and_nbm_qual_if: HIT_W must be at least 1");
  end
endinterface

// File: rtl/and_nbm_qual.sv
// Registered, qualified multi-lane AND with per-bit input inversion.
// Optional per-lane rise counter enabled by defining AND_HIT_COUNT_EN.
module and_nbm_qual #(
  parameter int unsigned      WIDTH    = 5,
  parameter logic [WIDTH-1:0] INV_MASK = WIDTH'(5'b00011),
  parameter int unsigned      CHANNELS = 1,
  parameter int unsigned      QUAL     = 1,
  parameter int unsigned      HIT_W    = 8
) (
  input logic           C,
  input logic           CLR,
  and_nbm_qual_if.slave bus
);
  localparam int unsigned   CW   = $clog2(QUAL + 1);
  localparam logic [CW-1:0] QMAX = CW'(QUAL);

  if (QUAL == 0) begin : g_bad_qual
    $error("and_nbm_qual: QUAL must be at least 1");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("and_nbm_qual: WIDTH must be in 2..16");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("and_nbm_qual: CHANNELS must be in 1..32");
  end
  if (HIT_W < 1) begin : g_bad_hit_w
    $error("and_nbm_qual: HIT_W must be at least 1");
  end

  logic [CHANNELS-1:0][CW-1:0] cnt;
  logic [CHANNELS-1:0][CW-1:0] cnt_next;
  logic [CHANNELS-1:0]         term;
  logic [CHANNELS-1:0]         o_next;
  logic [CHANNELS-1:0]         rise_next;
  logic [CHANNELS-1:0]         o_q;
  logic [CHANNELS-1:0]         rise_q;

  // Counter saturates at QUAL; any false sample restarts qualification.
  always_comb begin
    term     = '0;
    cnt_next = '0;
    o_next   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      term[c] = &(bus.I[c*WIDTH +: WIDTH] ^ INV_MASK);
      if (!term[c])
        cnt_next[c] = '0;
      else if (cnt[c] == QMAX)
        cnt_next[c] = QMAX;
      else
        cnt_next[c] = cnt[c] + CW'(1);
      o_next[c] = (cnt_next[c] == QMAX);
    end
    rise_next = o_next & ~o_q;
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      cnt    <= '0;
      o_q    <= '0;
      rise_q <= '0;
    end else if (bus.CE) begin
      cnt    <= cnt_next;
      o_q    <= o_next;
      rise_q <= rise_next;
    end else begin
      rise_q <= '0;
    end
  end

  assign bus.O    = o_q;
  assign bus.RISE = rise_q;

`ifdef AND_HIT_COUNT_EN
  logic [CHANNELS-1:0][HIT_W-1:0] hits;

  // HCLR takes priority over a rise on the same enabled edge.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      hits <= '0;
    end else if (bus.CE) begin
      if (bus.HCLR) begin
        hits <= '0;
      end else begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (rise_next[c] && (hits[c] != '1))
            hits[c] <= hits[c] + HIT_W'(1);
        end
      end
    end
  end

  assign bus.HITS = hits;
`endif
endmodule

// File: tb/tb_and_nbm_qual.sv
// Self-checking bench for and_nbm_qual: four differently configured instances
// compared each cycle against a run-length reference model.
module tb_and_nbm_qual;
  localparam int NI = 4;

  logic C = 1'b0;
  logic CLR;

  int wid  [NI] = '{5, 5, 16, 16};
  int qv   [NI] = '{1, 4, 3, 1};
  int chn  [NI] = '{1, 3, 2, 1};
  int hw   [NI] = '{2, 8, 8, 8};
  int hmax [NI] = '{3, 255, 255, 255};
  logic [15:0] pat [NI] = '{16'h001C, 16'h001C, 16'h0000, 16'hFFFF};

  int run [NI][3];
  bit oe  [NI][3];
  bit re  [NI][3];
  int he  [NI][3];

  int nvec = 0;
  int nerr = 0;

  and_nbm_qual_if #(.WIDTH(5),  .CHANNELS(1), .HIT_W(2)) b0 ();
  and_nbm_qual_if #(.WIDTH(5),  .CHANNELS(3), .HIT_W(8)) b1 ();
  and_nbm_qual_if #(.WIDTH(16), .CHANNELS(2), .HIT_W(8)) b2 ();
  and_nbm_qual_if #(.WIDTH(16), .CHANNELS(1), .HIT_W(8)) b3 ();

  and_nbm_qual #(.WIDTH(5), .INV_MASK(5'b00011), .CHANNELS(1), .QUAL(1), .HIT_W(2))
    u0 (.C(C), .CLR(CLR), .bus(b0));
  and_nbm_qual #(.WIDTH(5), .INV_MASK(5'b00011), .CHANNELS(3), .QUAL(4), .HIT_W(8))
    u1 (.C(C), .CLR(CLR), .bus(b1));
  and_nbm_qual #(.WIDTH(16), .INV_MASK(16'hFFFF), .CHANNELS(2), .QUAL(3), .HIT_W(8))
    u2 (.C(C), .CLR(CLR), .bus(b2));
  and_nbm_qual #(.WIDTH(16), .INV_MASK(16'h0000), .CHANNELS(1), .QUAL(1), .HIT_W(8))
    u3 (.C(C), .CLR(CLR), .bus(b3));

  always #5 C = ~C;

  function automatic logic [47:0] get_i(int k);
    case (k)
      0: return 48'(b0.I);
      1: return 48'(b1.I);
      2: return 48'(b2.I);
      default: return 48'(b3.I);
    endcase
  endfunction

  function automatic logic get_ce(int k);
    case (k)
      0: return b0.CE;
      1: return b1.CE;
      2: return b2.CE;
      default: return b3.CE;
    endcase
  endfunction

  function automatic logic [2:0] get_o(int k);
    case (k)
      0: return 3'(b0.O);
      1: return b1.O;
      2: return 3'(b2.O);
      default: return 3'(b3.O);
    endcase
  endfunction

  function automatic logic [2:0] get_r(int k);
    case (k)
      0: return 3'(b0.RISE);
      1: return b1.RISE;
      2: return 3'(b2.RISE);
      default: return 3'(b3.RISE);
    endcase
  endfunction

`ifdef AND_HIT_COUNT_EN
  function automatic logic [23:0] get_h(int k);
    case (k)
      0: return 24'(b0.HITS);
      1: return b1.HITS;
      2: return 24'(b2.HITS);
      default: return 24'(b3.HITS);
    endcase
  endfunction

  function automatic logic get_hclr(int k);
    case (k)
      0: return b0.HCLR;
      1: return b1.HCLR;
      2: return b2.HCLR;
      default: return b3.HCLR;
    endcase
  endfunction

  task automatic set_hclr(int k, logic h);
    case (k)
      0: b0.HCLR = h;
      1: b1.HCLR = h;
      2: b2.HCLR = h;
      default: b3.HCLR = h;
    endcase
  endtask

  function automatic logic [23:0] exp_h(int k);
    logic [23:0] e = '0;
    for (int c = 0; c < chn[k]; c++) e |= 24'(he[k][c]) << (c * hw[k]);
    return e;
  endfunction
`endif

  task automatic drive(int k, logic [47:0] v, logic ce);
    case (k)
      0: begin b0.I = v[4:0];  b0.CE = ce; end
      1: begin b1.I = v[14:0]; b1.CE = ce; end
      2: begin b2.I = v[31:0]; b2.CE = ce; end
      default: begin b3.I = v[15:0]; b3.CE = ce; end
    endcase
  endtask

  function automatic logic [2:0] exp_o(int k);
    logic [2:0] e = '0;
    for (int c = 0; c < chn[k]; c++) e[c] = oe[k][c];
    return e;
  endfunction

  function automatic logic [2:0] exp_r(int k);
    logic [2:0] e = '0;
    for (int c = 0; c < chn[k]; c++) e[c] = re[k][c];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < 3; c++) begin
        run[k][c] = 0; oe[k][c] = 0; re[k][c] = 0; he[k][c] = 0;
      end
  endtask

  // Output is high once the lane has matched its pattern on QUAL enabled samples in a row.
  task automatic model_step();
    logic [47:0] iv;
    logic [47:0] m;
    logic [15:0] lane;
    bit now;
    for (int k = 0; k < NI; k++) begin
      iv = get_i(k);
      m  = (48'd1 << wid[k]) - 48'd1;
      for (int c = 0; c < chn[k]; c++) begin
        if (!get_ce(k)) begin
          re[k][c] = 0;
        end else begin
          lane = 16'((iv >> (c * wid[k])) & m);
          run[k][c] = (lane == pat[k]) ? run[k][c] + 1 : 0;
          if (run[k][c] > 1000) run[k][c] = 1000;
          now = (run[k][c] >= qv[k]);
          re[k][c] = now && !oe[k][c];
          oe[k][c] = now;
`ifdef AND_HIT_COUNT_EN
          if (get_hclr(k)) he[k][c] = 0;
          else if (re[k][c] && he[k][c] < hmax[k]) he[k][c]++;
`endif
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge C);
    #1;
  endtask

  task automatic idle_others(int keep);
    for (int k = 0; k < NI; k++) if (k != keep) drive(k, get_i(k), 1'b0);
  endtask

  task automatic test_reset();
    @(posedge C);
    #1;
    for (int k = 0; k < NI; k++) begin
      nvec++;
      if (get_o(k) !== 3'b000 || get_r(k) !== 3'b000) begin
        nerr++;
        $display("FAIL reset inst%0d: O=%b RISE=%b required 000/000", k, get_o(k), get_r(k));
      end
`ifdef AND_HIT_COUNT_EN
      nvec++;
      if (get_h(k) !== 24'd0) begin
        nerr++;
        $display("FAIL reset_hits inst%0d: HITS=%h required 0", k, get_h(k));
      end
`endif
    end
    @(negedge C);
    CLR = 1'b0;
    model_reset();
  endtask

  task automatic test_default();
    logic [4:0] seq [6] = '{5'b11100, 5'b11100, 5'b11101, 5'b11100, 5'b00000, 5'b11100};
    idle_others(0);
    for (int s = 0; s < 6; s++) begin
      drive(0, 48'(seq[s]), 1'b1);
      tick();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (get_o(k) !== exp_o(k) || get_r(k) !== exp_r(k)) begin
          nerr++;
          $display("FAIL default inst%0d step%0d: O=%b RISE=%b required O=%b RISE=%b",
                   k, s, get_o(k), get_r(k), exp_o(k), exp_r(k));
        end
      end
      if (s == 0) begin
        nvec++;
        if (get_o(0) !== 3'b001 || get_r(0) !== 3'b001) begin
          nerr++;
          $display("FAIL default_first_edge: O=%b RISE=%b required 001/001", get_o(0), get_r(0));
        end
      end
    end
  endtask

  task automatic test_qual();
    bit t [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int rises = 0;
    logic [4:0] l0;
    idle_others(1);
    for (int s = 0; s < 9; s++) begin
      l0 = t[s] ? 5'b11100 : 5'b10100;
      drive(1, {33'd0, 5'($urandom), 5'($urandom), l0}, 1'b1);
      tick();
      if (get_r(1)[0] === 1'b1) rises++;
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (get_o(k) !== exp_o(k) || get_r(k) !== exp_r(k)) begin
          nerr++;
          $display("FAIL qual inst%0d step%0d: O=%b RISE=%b required O=%b RISE=%b",
                   k, s, get_o(k), get_r(k), exp_o(k), exp_r(k));
        end
      end
    end
    nvec++;
    if (rises != 1 || get_o(1)[0] !== 1'b1) begin
      nerr++;
      $display("FAIL qual_single_rise: rises=%0d O0=%b required 1/1", rises, get_o(1)[0]);
    end
  endtask

  task automatic test_channels_ce();
    logic [2:0] prev_r = '0;
    idle_others(1);
    drive(1, 48'd0, 1'b1);
    tick();
    for (int s = 0; s < 12; s++) begin
      drive(1, {33'd0, 5'b00000, 5'b11100, 5'b00000}, (s % 2 == 0));
      tick();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (get_o(k) !== exp_o(k) || get_r(k) !== exp_r(k)) begin
          nerr++;
          $display("FAIL channels_ce inst%0d step%0d: O=%b RISE=%b required O=%b RISE=%b",
                   k, s, get_o(k), get_r(k), exp_o(k), exp_r(k));
        end
      end
      nvec++;
      if ((prev_r & get_r(1)) !== 3'b000) begin
        nerr++;
        $display("FAIL rise_stretch step%0d: RISE prev=%b now=%b required no overlap",
                 s, prev_r, get_r(1));
      end
      prev_r = get_r(1);
    end
  endtask

  task automatic clr_pulse(string tag);
    #3;
    CLR = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      nvec++;
      if (get_o(k) !== 3'b000 || get_r(k) !== 3'b000) begin
        nerr++;
        $display("FAIL %s inst%0d: O=%b RISE=%b required 000/000", tag, k, get_o(k), get_r(k));
      end
    end
    model_reset();
    #1;
    CLR = 1'b0;
  endtask

  task automatic test_clr();
    idle_others(2);
    drive(2, 48'hFFFF_FFFF, 1'b1);
    tick();
    drive(2, 48'hFFFF_0000, 1'b1);
    tick();
    tick();
    clr_pulse("clr_midcount");
    for (int s = 1; s <= 4; s++) begin
      tick();
      nvec++;
      if (get_o(2)[0] !== (s >= 3) || get_o(2) !== exp_o(2) || get_r(2) !== exp_r(2)) begin
        nerr++;
        $display("FAIL clr_requal edge%0d: O=%b RISE=%b required O=%b RISE=%b",
                 s, get_o(2), get_r(2), exp_o(2), exp_r(2));
      end
    end
    clr_pulse("clr_while_high");
  endtask

  task automatic test_width16();
    logic [15:0] vals [7];
    vals = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
    vals[6] = 16'($urandom);
    drive(0, get_i(0), 1'b0);
    drive(1, get_i(1), 1'b0);
    for (int s = 0; s < 7; s++) begin
      drive(2, {16'd0, ~vals[s], vals[s]}, 1'b1);
      drive(3, 48'(vals[s]), 1'b1);
      for (int r = 0; r < 3; r++) begin
        tick();
        for (int k = 2; k < NI; k++) begin
          nvec++;
          if (get_o(k) !== exp_o(k) || get_r(k) !== exp_r(k)) begin
            nerr++;
            $display("FAIL width16 inst%0d val=%h rep%0d: O=%b RISE=%b required O=%b RISE=%b",
                     k, vals[s], r, get_o(k), get_r(k), exp_o(k), exp_r(k));
          end
        end
      end
    end
  endtask

`ifdef AND_HIT_COUNT_EN
  task automatic test_hits();
    idle_others(0);
    set_hclr(0, 1'b1);
    drive(0, 48'd0, 1'b1);
    tick();
    set_hclr(0, 1'b0);
    for (int s = 0; s < 10; s++) begin
      drive(0, (s % 2 == 0) ? 48'h1C : 48'h00, 1'b1);
      tick();
      nvec++;
      if (get_h(0) !== exp_h(0)) begin
        nerr++;
        $display("FAIL hits step%0d: HITS=%h required %h", s, get_h(0), exp_h(0));
      end
    end
    nvec++;
    if (get_h(0) !== 24'd3) begin
      nerr++;
      $display("FAIL hits_saturate: HITS=%h required 3", get_h(0));
    end
    drive(0, 48'h1C, 1'b1);
    set_hclr(0, 1'b1);
    tick();
    set_hclr(0, 1'b0);
    nvec++;
    if (get_h(0) !== 24'd0 || get_r(0) !== 3'b001 || get_h(0) !== exp_h(0)) begin
      nerr++;
      $display("FAIL hclr_priority: HITS=%h RISE=%b required 0/001", get_h(0), get_r(0));
    end
  endtask
`endif

  task automatic test_random();
    logic [47:0] v;
    logic [15:0] lane;
    int r;
    for (int s = 0; s < 300; s++) begin
      for (int k = 0; k < NI; k++) begin
        v = '0;
        for (int c = 0; c < chn[k]; c++) begin
          r = $urandom_range(0, 9);
          if (r < 6) lane = pat[k];
          else if (r < 8) lane = pat[k] ^ (16'd1 << $urandom_range(0, wid[k] - 1));
          else lane = 16'($urandom);
          v |= (48'(lane) & ((48'd1 << wid[k]) - 48'd1)) << (c * wid[k]);
        end
        drive(k, v, ($urandom_range(0, 3) != 0));
`ifdef AND_HIT_COUNT_EN
        set_hclr(k, ($urandom_range(0, 19) == 0));
`endif
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (get_o(k) !== exp_o(k) || get_r(k) !== exp_r(k)) begin
          nerr++;
          $display("FAIL random inst%0d cyc%0d: O=%b RISE=%b required O=%b RISE=%b",
                   k, s, get_o(k), get_r(k), exp_o(k), exp_r(k));
        end
`ifdef AND_HIT_COUNT_EN
        nvec++;
        if (get_h(k) !== exp_h(k)) begin
          nerr++;
          $display("FAIL random_hits inst%0d cyc%0d: HITS=%h required %h",
                   k, s, get_h(k), exp_h(k));
        end
`endif
      end
    end
  endtask

  initial begin
    CLR = 1'b1;
    for (int k = 0; k < NI; k++) begin
      drive(k, 48'd0, 1'b0);
`ifdef AND_HIT_COUNT_EN
      set_hclr(k, 1'b0);
`endif
    end
    model_reset();
    test_reset();
    test_default();
    test_qual();
    test_channels_ce();
    test_clr();
    test_width16();
`ifdef AND_HIT_COUNT_EN
    test_hits();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
